// File: rtl/muldiv_sequencer.sv
// Purpose : iterative RV32M multiply/divide unit beside the EX-stage ALU; one radix-2
//           shift-add (mul) or restoring shift-subtract (div) step per cycle.
// Latency : fixed XLEN+3 cycles from accepted start to the done pulse (35 for XLEN=32),
//           identical for every op and every special case.
// Backpressure: stall_o holds IF/ID/EX while an op is in flight. It drops in the DONE
//           cycle so EX advances and captures result_o. A start is only accepted in IDLE or DONE.
//
// Ports:
//   clk_i      clock; all state updates on the rising edge
//   reset_i    synchronous, active-high reset
//   start_i    request pulse from EX (valid M-type instruction)
//   op_i       func3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
//   rs1_i      operand A (multiplicand / dividend)
//   rs2_i      operand B (multiplier / divisor)
//   flush_i    squash of EX; aborts the current op without a done pulse
//   busy_o     high in any state other than IDLE (registered)
//   stall_o    pipeline freeze (combinational from start_i and state)
//   done_o     one-cycle result-valid pulse (registered)
//   result_o   final value, held until the next op completes
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;          // latched rs1 (also the rem-by-zero result)
  logic [XLEN-1:0]   b_q, b_d;          // latched rs2
  logic [XLEN-1:0]   m_q, m_d;          // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] w_q, w_d;          // hi:lo product, or remainder:quotient
  logic              neg_q, neg_d;      // negate the final value
  logic              dz_q, dz_d;        // divide by zero
  logic              ovf_q, ovf_d;      // signed overflow (MIN / -1)
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;

  // ---------------------------------------------------------------------------
  // Op decode (from the latched op, valid from PREP onwards)
  // ---------------------------------------------------------------------------
  logic            is_div, is_rem, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_div = op_q[2];
  assign is_rem = op_q[2] & op_q[1];
  // rs1 is signed for mulh, mulhsu, div, rem; rs2 for mulh, div, rem.
  assign sgn_a  = (op_q == 3'b001) | (op_q == 3'b010) | (op_q[2] & ~op_q[0]);
  assign sgn_b  = (op_q == 3'b001) | (op_q[2] & ~op_q[0]);
  assign neg_a  = sgn_a & a_q[XLEN-1];
  assign neg_b  = sgn_b & b_q[XLEN-1];
  assign abs_a  = neg_a ? -a_q : a_q;
  assign abs_b  = neg_b ? -b_q : b_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, accept strobe and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = start_i;
        if (start_i) begin
          state_d = S_PREP;
          accept  = 1'b1;
        end
      end
      S_PREP: begin
        stall_o = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        stall_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        stall_o = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Back-to-back: a start here is taken immediately.
        stall_o = start_i;
        if (start_i) begin
          state_d = S_PREP;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // flush beats start; stall stays a pure function of start and state.
    if (flush_i) begin
      state_d = S_IDLE;
      accept  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath step logic
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;    // upper half plus multiplicand, with carry
  logic [2*XLEN:0]   shifted;    // remainder:quotient shifted left one bit
  logic [XLEN:0]     diff;       // trial subtract; diff[XLEN] is the borrow
  logic [2*XLEN-1:0] prod_fix;   // signed-corrected full product
  logic [XLEN-1:0]   div_word;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   fix_val;

  // Final-value selection used in FIX.
  always_comb begin
    prod_fix = neg_q ? -w_q : w_q;
    div_word = is_rem ? w_q[2*XLEN-1:XLEN] : w_q[XLEN-1:0];
    div_fix  = neg_q ? -div_word : div_word;
    if (is_div) begin
      fix_val = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_val = prod_fix[XLEN-1:0];
    end else begin
      fix_val = prod_fix[2*XLEN-1:XLEN];
    end
    // Special cases override whatever the iteration produced.
    if (dz_q) begin
      fix_val = is_rem ? a_q : {XLEN{1'b1}};
    end else if (ovf_q) begin
      fix_val = is_rem ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    mul_sum  = '0;
    shifted  = '0;
    diff     = '0;

    if (accept) begin
      op_d = op_i;
      a_d  = rs1_i;
      b_d  = rs2_i;
    end

    case (state_q)
      S_PREP: begin
        // Iterate on magnitudes; the sign is restored in FIX.
        if (is_div) begin
          w_d = {{XLEN{1'b0}}, abs_a};
          m_d = abs_b;
        end else begin
          w_d = {{XLEN{1'b0}}, abs_b};
          m_d = abs_a;
        end
        // Remainder takes the dividend's sign; products and quotients take the xor.
        neg_d = is_rem ? neg_a : (neg_a ^ neg_b);
        dz_d  = is_div & (b_q == {XLEN{1'b0}});
        ovf_d = is_div & ~op_q[0] & (a_q == MIN_NEG) & (b_q == {XLEN{1'b1}});
        cnt_d = '0;
      end
      S_CALC: begin
        if (!is_div) begin
          // Shift-add: the multiplier is consumed from the low half as the
          // product grows into it from the top.
          mul_sum = w_q[0] ? ({1'b0, w_q[2*XLEN-1:XLEN]} + {1'b0, m_q})
                           : {1'b0, w_q[2*XLEN-1:XLEN]};
          w_d     = {mul_sum, w_q[XLEN-1:1]};
        end else begin
          // Restoring divide: keep the subtraction only when it did not borrow.
          shifted = {w_q, 1'b0};
          diff    = shifted[2*XLEN:XLEN] - {1'b0, m_q};
          if (!diff[XLEN]) begin
            w_d = {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
          end else begin
            w_d = shifted[2*XLEN-1:0];
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        // A flush here aborts without touching the visible result.
        if (!flush_i) begin
          result_d = fix_val;
        end
      end
      default: begin
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
  localparam int LAT  = 35;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, stall, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .flush_i  (flush),
    .busy_o   (busy),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_res = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics from plain wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [64:0] xa, xb, p;
    int signed          ia, ib;
    ia = a;
    ib = b;
    xa = (f == 3'd1 || f == 3'd2) ? {{33{a[31]}}, a} : {33'b0, a};
    xb = (f == 3'd1) ? {{33{b[31]}}, b} : {33'b0, b};
    p  = xa * xb;
    case (f)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result_op%0d", mon_e.op), result, mon_e.res);
        chk($sformatf("latency_op%0d", mon_e.op), 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Call just after a negedge. Holds start for one cycle.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
    exp_t e;
    op    = f;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    if (push) begin
      e.res = exp;
      e.cyc = cyc + LAT;
      e.op  = f;
      sb.push_back(e);
    end
    #1;
    chk("stall_on_start", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done(input logic [31:0] exp);
    bit bad  = 1'b0;
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    chk("done_seen", {31'b0, seen}, 32'h1);
    chk("stall_busy_held", {31'b0, bad}, 32'h0);
    if (seen) begin
      chk("stall_low_in_done", {31'b0, stall}, 32'h0);
      last_res = exp;
    end
  endtask

  logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                             3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
  logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2,
                             32'd7, 32'd7, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_r  [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                             32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
                             32'hFFFF_FFFF, 32'd5};

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int          n_done;
    logic [2:0]  f;
    logic [31:0] a, b;

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    rs1   = 32'h0;
    rs2   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'b0, busy},  32'h0);
    chk("reset_done",   {31'b0, done},  32'h0);
    chk("reset_stall",  {31'b0, stall}, 32'h0);
    chk("reset_result", result,         32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table, chained back-to-back (each start lands in the DONE cycle).
    for (int i = 0; i < 14; i++) begin
      start_op(d_op[i], d_a[i], d_b[i], d_r[i], 1'b1);
      wait_done(d_r[i]);
    end
    @(negedge clk);
    @(negedge clk);

    // flush together with start in IDLE: start is ignored.
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd0;
    rs1   = 32'd3;
    rs2   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_idle_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);

    // flush ten cycles into an op: abort, no done, result held.
    start_op(3'd5, 32'd1000, 32'd3, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy",   {31'b0, busy},  32'h0);
    chk("flush_stall",  {31'b0, stall}, 32'h0);
    chk("flush_result", result,         last_res);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("flush_no_done", 32'(n_done), 32'h0);
    chk("flush_result_held", result, last_res);
    start_op(3'd0, 32'd12345, 32'd678, model(3'd0, 32'd12345, 32'd678), 1'b1);
    wait_done(model(3'd0, 32'd12345, 32'd678));
    @(negedge clk);

    // Reset during CALC clears every output.
    start_op(3'd4, 32'hDEAD_BEEF, 32'd17, 32'h0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_busy",   {31'b0, busy},  32'h0);
    chk("midreset_done",   {31'b0, done},  32'h0);
    chk("midreset_stall",  {31'b0, stall}, 32'h0);
    chk("midreset_result", result,         32'h0);
    reset    = 1'b0;
    last_res = 32'h0;
    @(negedge clk);
    start_op(3'd7, 32'd99, 32'd10, 32'd9, 1'b1);
    wait_done(32'd9);

    // Random ops, random idle gaps (zero gap means back-to-back).
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(f, a, b, model(f, a, b), 1'b1);
      wait_done(model(f, a, b));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
